// File: rtl/time_keeper.sv
// time_keeper: binary hh:mm:ss time-of-day counter with button set mode; TIME_KEEPER_AUTO_REPEAT_EN adds held-button auto-repeat
module time_keeper #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int REPEAT_CYC    = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_time,
  input  logic       set_hr,
  input  logic       set_min,
  output logic [7:0] hr,
  output logic [7:0] min,
  output logic [5:0] sec,
  output logic       sec_pulse,
  output logic       min_pulse,
  output logic       setting
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  typedef enum logic {RUN, SET} state_t;
  state_t state, state_d;
  logic [PW-1:0] presc, presc_d;
  logic [7:0] hr_d, min_d;
  logic [5:0] sec_d;
  logic hr_prev, min_prev, hr_edge, min_edge, hr_rep, min_rep;
  logic run, tick, sec_wrap, min_wrap, inc_hr, inc_min;
  assign hr_edge = set_hr & ~hr_prev;
  assign min_edge = set_min & ~min_prev;
  assign setting = state == SET;
`ifdef TIME_KEEPER_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYC + 1);
  logic [RW-1:0] hr_cnt, min_cnt;
  assign hr_rep = set_hr && hr_cnt == RW'(REPEAT_CYC);
  assign min_rep = set_min && min_cnt == RW'(REPEAT_CYC);
  // repeat timers arm on a SET-mode edge and restart each time they fire; a button already held never arms them
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hr_cnt <= '0;
      min_cnt <= '0;
    end else begin
      hr_cnt <= !(set_hr && state == SET) ? '0 : hr_edge ? RW'(1) : hr_cnt == '0 ? '0 : hr_rep ? RW'(1) : hr_cnt + 1'b1;
      min_cnt <= !(set_min && state == SET) ? '0 : min_edge ? RW'(1) : min_cnt == '0 ? '0 : min_rep ? RW'(1) : min_cnt + 1'b1;
    end
`else
  assign hr_rep = 1'b0;
  assign min_rep = 1'b0;
`endif
  // next state and next time; counting only while RUN is both current and next, so entry and exit edges clear the prescaler
  always_comb begin
    state_d = set_time ? SET : RUN;
    run = state == RUN && !set_time;
    tick = run && presc == PW'(TICKS_PER_SEC - 1);
    sec_wrap = tick && sec == 6'd59;
    min_wrap = sec_wrap && min == 8'd59;
    inc_hr = state == SET && (hr_edge || hr_rep);
    inc_min = state == SET && (min_edge || min_rep);
    presc_d = (!run || tick) ? '0 : presc + 1'b1;
    sec_d = !run ? '0 : tick ? (sec == 6'd59 ? '0 : sec + 6'd1) : sec;
    min_d = (sec_wrap || inc_min) ? (min == 8'd59 ? '0 : min + 8'd1) : min;
    hr_d = (min_wrap || inc_hr) ? (hr == 8'd23 ? '0 : hr + 8'd1) : hr;
  end
  // state, time, strobes and button history registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RUN;
      presc <= '0;
      sec <= '0;
      min <= '0;
      hr <= '0;
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
      hr_prev <= 1'b0;
      min_prev <= 1'b0;
    end else begin
      state <= state_d;
      presc <= presc_d;
      sec <= sec_d;
      min <= min_d;
      hr <= hr_d;
      sec_pulse <= tick;
      min_pulse <= sec_wrap;
      hr_prev <= set_hr;
      min_prev <= set_min;
    end
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: randomized scoreboard bench for time_keeper against a seconds-of-day reference model
module tb_time_keeper;
  localparam int TPS = 4;
  localparam int REP = 3;
  logic clk = 1'b0, rst = 1'b0, set_time = 1'b0, set_hr = 1'b0, set_min = 1'b0;
  logic [7:0] hr, min;
  logic [5:0] sec;
  logic sec_pulse, min_pulse, setting;
  int checks = 0, passed = 0;
  typedef struct packed {logic [7:0] hr; logic [7:0] mn; logic [5:0] sec; logic sp; logic mp; logic st;} exp_t;
  exp_t q[$];
  int m_tod, m_cnt, m_hk, m_mk;
  bit m_set, m_ph, m_pm;

  time_keeper #(.TICKS_PER_SEC(TPS), .REPEAT_CYC(REP)) dut (
    .clk(clk), .rst(rst), .set_time(set_time), .set_hr(set_hr), .set_min(set_min),
    .hr(hr), .min(min), .sec(sec), .sec_pulse(sec_pulse), .min_pulse(min_pulse), .setting(setting)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit fires(int k);
`ifdef TIME_KEEPER_AUTO_REPEAT_EN
    return k >= 0 && k % REP == 0;
`else
    return k == 0;
`endif
  endfunction

  task automatic model_reset();
    m_tod = 0; m_cnt = 0; m_hk = -1; m_mk = -1;
    m_set = 0; m_ph = 0; m_pm = 0;
  endtask

  // called at posedge+1: drive inputs, advance model over the next edge, queue its expected outputs
  task automatic cyc(input bit st, input bit bh, input bit bm);
    exp_t e;
    bit inc_h, inc_m;
    int h, mi;
    set_time = st; set_hr = bh; set_min = bm;
    m_hk = (m_set && bh) ? (!m_ph ? 0 : (m_hk >= 0 ? m_hk + 1 : -1)) : -1;
    m_mk = (m_set && bm) ? (!m_pm ? 0 : (m_mk >= 0 ? m_mk + 1 : -1)) : -1;
    inc_h = m_set && fires(m_hk);
    inc_m = m_set && fires(m_mk);
    e.sp = 0; e.mp = 0;
    if (!m_set && !st) begin
      if (m_cnt == TPS - 1) begin
        m_cnt = 0;
        m_tod = (m_tod + 1) % 86400;
        e.sp = 1;
        e.mp = (m_tod % 60 == 0);
      end else m_cnt++;
    end else begin
      m_cnt = 0;
      m_tod -= m_tod % 60;
    end
    if (m_set) begin
      h = m_tod / 3600;
      mi = (m_tod / 60) % 60;
      if (inc_h) h = (h + 1) % 24;
      if (inc_m) mi = (mi + 1) % 60;
      m_tod = h * 3600 + mi * 60;
    end
    m_set = st; m_ph = bh; m_pm = bm;
    e.hr = 8'(m_tod / 3600);
    e.mn = 8'((m_tod / 60) % 60);
    e.sec = 6'(m_tod % 60);
    e.st = m_set;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic press(input bit bh, input bit bm);
    cyc(1, bh, bm);
    cyc(1, 0, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("scoreboard", 32'({hr, min, sec, sec_pulse, min_pulse, setting}), 32'(e));
    end
  end

  initial begin
    int n, sp_n, mp_n, mp_at;
    bit mp_seen, st, bh, bm;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("reset_state", 32'({hr, min, sec, sec_pulse, min_pulse, setting}), 0);
    rst = 1;
    mp_seen = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0);
      chk("run_sec_pulse", 32'(sec_pulse), 32'(i % 4 == 3));
      mp_seen |= min_pulse;
    end
    chk("run_sec", 32'(sec), 4);
    chk("run_hr_min", 32'({hr, min}), 0);
    chk("run_no_min_pulse", 32'(mp_seen), 0);
    cyc(1, 0, 0);
    repeat (23) press(1, 0);
    repeat (59) press(0, 1);
    cyc(0, 0, 0);
    repeat (58 * TPS) cyc(0, 0, 0);
    chk("preset", 32'({hr, min, sec}), 32'({8'd23, 8'd59, 6'd58}));
    sp_n = 0; mp_n = 0; mp_at = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0);
      if (sec_pulse) sp_n++;
      if (min_pulse) begin mp_n++; mp_at = sp_n; end
    end
    chk("rollover_mp_count", 32'(mp_n), 1);
    chk("rollover_mp_on_2nd", 32'(mp_at), 2);
    chk("rollover_time", 32'({hr, min, sec}), 0);
    cyc(1, 0, 0);
    repeat (25) press(1, 0);
    chk("set_hr_wrap", 32'(hr), 1);
    repeat (61) press(0, 1);
    chk("set_min_wrap", 32'({hr, min}), 32'({8'd1, 8'd1}));
    chk("set_sec_setting", 32'({sec, setting}), 32'({6'd0, 1'b1}));
    press(1, 1);
    chk("simultaneous", 32'({hr, min}), 32'({8'd2, 8'd2}));
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("run_button_ignored", 32'(hr), 2);
    repeat (4) cyc(1, 1, 0);
    chk("held_on_entry", 32'(hr), 2);
    cyc(1, 0, 0);
    repeat (10) cyc(1, 0, 1);
    cyc(1, 0, 0);
`ifdef TIME_KEEPER_AUTO_REPEAT_EN
    chk("auto_repeat", 32'(min), 6);
`else
    chk("auto_repeat", 32'(min), 3);
`endif
    cyc(0, 0, 0);
    chk("exit_setting", 32'(setting), 0);
    n = 0;
    do begin
      cyc(0, 0, 0);
      n++;
    end while (!sec_pulse && n < 20);
    chk("exit_first_pulse", 32'(n), 4);
    st = 0; bh = 0; bm = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(29) == 0) st = !st;
      if ($urandom_range(3) == 0) bh = 1'($urandom_range(1));
      if ($urandom_range(3) == 0) bm = 1'($urandom_range(1));
      cyc(st, bh, bm);
    end
    repeat (7) cyc(0, 0, 0);
    @(negedge clk); #1;
    set_time = 0; set_hr = 0; set_min = 0;
    rst = 0;
    #1;
    chk("async_reset", 32'({hr, min, sec, sec_pulse, min_pulse, setting}), 0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    repeat (8) cyc(0, 0, 0);
    chk("post_reset_run", 32'({hr, min, sec}), 2);
    @(negedge clk); #1;
    chk("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/time_keeper.md
# time_keeper

Time-of-day source for the alarm clock subsystem. Counts seconds, minutes and hours from a free-running clock through a parameterised prescaler. Provides a button-driven set-time mode and drives the `hr`/`min` buses that the alarm FSM compares against its stored alarm time. All arithmetic is binary (hr 0–23, min 0–59), matching the alarm block's binary compare.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clk cycles per second; must be ≥2.
- `REPEAT_CYC`, default 25_000_000: auto-repeat interval in cycles; used only with `TIME_KEEPER_AUTO_REPEAT_EN`; must be ≥1.

- `clk` input 1: system clock, rising-edge.
- `rst` input 1: reset, asynchronous, active-low.
- `set_time` input 1: level; 1 requests set-time mode.
- `set_hr` input 1: button; a rising edge in set mode increments the hour.
- `set_min` input 1: button; a rising edge in set mode increments the minute.
- `hr` output 8: current hour, binary 0–23, registered.
- `min` output 8: current minute, binary 0–59, registered.
- `sec` output 6: current second, binary 0–59, registered.
- `sec_pulse` output 1: one-cycle strobe on each second rollover.
- `min_pulse` output 1: one-cycle strobe on each minute rollover (sec 59→0).
- `setting` output 1: 1 while the FSM is in SET.

All inputs are synchronous to `clk` and debounced upstream.

## Operation
- **Reset values** (`rst` low):
  - state = RUN; `hr` = 0, `min` = 0, `sec` = 0; prescaler = 0.
  - `sec_pulse` = 0, `min_pulse` = 0, `setting` = 0.
  - Edge-detect registers = 0.
- **FSM, two states:**
  - RUN: if `set_time` = 1, go to SET; otherwise stay in RUN.
  - SET: if `set_time` = 0, go to RUN; otherwise stay in SET.
- **RUN**:
  - The prescaler counts 0..TICKS_PER_SEC-1 and wraps.
  - On the wrap cycle: `sec_pulse` = 1 and `sec` increments.
  - `sec` 59→0 sets `min_pulse` = 1 and increments `min`.
  - `min` 59→0 increments `hr`; `hr` 23→0.
  - Full rollover: 23:59:59 → 00:00:00.
- **SET**:
  - The prescaler and `sec` are held at 0; no pulses.
  - A rising edge on `set_hr` gives `hr` = (`hr`+1) mod 24.
  - A rising edge on `set_min` gives `min` = (`min`+1) mod 60, with no carry into `hr`.
  - Simultaneous edges on both buttons increment both.
- **Edge detect**:
  - The previous value of each button is registered every cycle, in every state.
  - A button already high when SET is entered does not increment.
- **Button edges in RUN** are ignored.
- **Reset mid-operation**: all state returns to its reset value immediately; no partial increment survives.

## Timing
- All outputs are registered. An update takes effect on the clock edge after the triggering condition is sampled.
- `sec_pulse` and the `sec` increment share one edge, so `sec_pulse` is high in the same cycle that `sec` shows the new value.
- `min_pulse` follows the same rule with respect to `min`.
- Cycle `set_time` is first sampled 1: the FSM enters SET on that edge.
  - On that same edge `setting` = 1, the prescaler is cleared and `sec` is cleared.
- Cycle `set_time` is first sampled 0 in SET: the FSM enters RUN with prescaler = 0.
  - The first `sec_pulse` arrives TICKS_PER_SEC cycles after that edge.
- Button latency: edge sampled in cycle N; the incremented value is visible in cycle N+1.

## Configuration
- `TIME_KEEPER_AUTO_REPEAT_EN` defined (auto-repeat enabled):
  - `set_hr` and `set_min` each own a repeat counter.
  - While in SET with the button continuously high, after the edge increment the field increments again every REPEAT_CYC cycles.
  - A counter clears when its button is low or the FSM is in RUN.
- `TIME_KEEPER_AUTO_REPEAT_EN` undefined: one increment per rising edge only; no repeat counters are synthesised.

## Test plan
Test values use TICKS_PER_SEC = 4 and REPEAT_CYC = 3.

- **Reset, then run.** Release reset and run 16 cycles → `sec_pulse` fires at cycles 4, 8, 12 and 16, and `sec` = 4. `hr`/`min` stay 0 and `min_pulse` never fires.
- **Minute and day rollover.** Preset 23:59:58 via set mode, then run 8 cycles in RUN:
  - `min_pulse` fires once, on the second `sec_pulse`;
  - time reads 00:00:00;
  - `hr` wraps 23→0.
- **Set-mode increments.**
  - Enter SET and pulse `set_hr` 25 times → `hr` = 1.
  - Pulse `set_min` 61 times → `min` = 1 and `hr` is unchanged.
  - `sec` = 0 throughout and `setting` = 1.
- **Simultaneous and held buttons.**
  - Rise both buttons in the same cycle → both fields increment by 1.
  - Hold `set_hr` high across SET entry → no increment.
  - Rise `set_hr` in RUN → no change.
- **Exit timing and reset.**
  - Drop `set_time` → `setting` = 0 next cycle and the first `sec_pulse` arrives 4 cycles later.
  - Assert `rst` mid-count → all outputs read 0 asynchronously.
- **Auto-repeat** (`TIME_KEEPER_AUTO_REPEAT_EN` defined). Hold `set_min` for 10 cycles in SET → `min` increases by 4: edge at cycle 1, repeats at cycles 4, 7 and 10. With the macro undefined, the same stimulus increases `min` by 1.
